// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle WIDTH-bit subtractor (a - b).
// One 4-bit slice is processed per clock, LSB slice first, using a
// propagate/generate lookahead on a + ~b + carry. A registered carry
// (inverted borrow) chains the slices together. Operands enter through a
// valid/ready handshake and the result leaves through another.
// Optional feature macro: SUB_SATURATE_EN -- when defined, an overflowing
// result is replaced by the signed saturation value of the minuend's sign.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;

    logic [WIDTH-1:0] aShift;
    logic [WIDTH-1:0] bShift;
    logic [3:0]       sliceA;
    logic [3:0]       sliceNotB;
    logic [3:0]       prop;
    logic [3:0]       gen;
    logic [4:0]       carries;
    logic [3:0]       sliceSum;
    logic [WIDTH-1:0] rawDiff;
    logic             rawOvf;
    logic [WIDTH-1:0] finalDiff;
    logic             lastSlice;

    // Select the current nibble and resolve its four carries by lookahead.
    always_comb begin
        aShift     = a_q >> {cnt_q, 2'b00};
        bShift     = b_q >> {cnt_q, 2'b00};
        sliceA     = aShift[3:0];
        sliceNotB  = ~bShift[3:0];
        prop       = sliceA ^ sliceNotB;
        gen        = sliceA & sliceNotB;
        carries[0] = carry_q;
        carries[1] = gen[0]
                   | (prop[0] & carries[0]);
        carries[2] = gen[1]
                   | (prop[1] & gen[0])
                   | (prop[1] & prop[0] & carries[0]);
        carries[3] = gen[2]
                   | (prop[2] & gen[1])
                   | (prop[2] & prop[1] & gen[0])
                   | (prop[2] & prop[1] & prop[0] & carries[0]);
        carries[4] = gen[3]
                   | (prop[3] & gen[2])
                   | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0])
                   | (prop[3] & prop[2] & prop[1] & prop[0] & carries[0]);
        sliceSum   = prop ^ carries[3:0];
    end

    // Assemble the full result as it will look after the last slice, and
    // derive overflow and the value that will actually be driven on diff.
    always_comb begin
        rawDiff   = {sliceSum, res_q[WIDTH-1:4]};
        rawOvf    = (a_q[MSB] != b_q[MSB]) && (rawDiff[MSB] != a_q[MSB]);
        finalDiff = rawDiff;
`ifdef SUB_SATURATE_EN
        if (rawOvf) begin
            finalDiff = a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    assign lastSlice = (cnt_q == CW'(NSLICE - 1));

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = rawDiff;
                carry_d = carries[4];
                cnt_d   = cnt_q + CW'(1);
                if (lastSlice) begin
                    diff_d   = finalDiff;
                    borrow_d = ~carries[4];
                    ovf_d    = rawOvf;
                    zero_d   = (finalDiff == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed bench for nibble_serial_subtractor
// at WIDTH = 16. Expected values are hand-computed constants; the
// SUB_SATURATE_EN macro selects the saturated expectations.
module tb_nibble_serial_subtractor;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    int checks;
    int errors;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair for a single accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    // Waits exactly NSLICE edges after accept and checks the result.
    task automatic checkResult(input string tag, input logic [WIDTH-1:0] expDiff,
                               input logic expBorrow, input logic expOvf);
        for (int i = 1; i < NSLICE; i++) begin
            tick();
            checkOutput({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        tick();
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_diff"},      32'(diff),      32'(expDiff));
        checkOutput({tag, "_borrow"},    32'(borrow),    32'(expBorrow));
        checkOutput({tag, "_ovf"},       32'(ovf),       32'(expOvf));
        checkOutput({tag, "_zero"},      32'(zero),      32'(expDiff == '0));
    endtask

    // Completes the output handshake and confirms return to IDLE.
    task automatic finishOp(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_diff",      32'(diff),      32'd0);
        checkOutput("rst_borrow",    32'(borrow),    32'd0);
        checkOutput("rst_ovf",       32'(ovf),       32'd0);
        checkOutput("rst_zero",      32'(zero),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] simple subtract and latency");
        applyStimulus(16'h1234, 16'h0234);
        checkResult("t1", 16'h1000, 1'b0, 1'b0);
        finishOp("t1");

        $display("[TB] borrow and equal operands");
        applyStimulus(16'h0000, 16'h0001);
        checkResult("t2a", 16'hFFFF, 1'b1, 1'b0);
        finishOp("t2a");
        applyStimulus(16'hA5A5, 16'hA5A5);
        checkResult("t2b", 16'h0000, 1'b0, 1'b0);
        finishOp("t2b");

        $display("[TB] signed overflow cases");
        applyStimulus(16'h8000, 16'h0001);
`ifdef SUB_SATURATE_EN
        checkResult("t3", 16'h8000, 1'b0, 1'b1);
`else
        checkResult("t3", 16'h7FFF, 1'b0, 1'b1);
`endif
        finishOp("t3");
        applyStimulus(16'h7FFF, 16'hFFFF);
`ifdef SUB_SATURATE_EN
        checkResult("t4", 16'h7FFF, 1'b1, 1'b1);
`else
        checkResult("t4", 16'h8000, 1'b1, 1'b1);
`endif
        finishOp("t4");

        $display("[TB] DONE hold with in_valid high");
        applyStimulus(16'h5555, 16'h1111);
        checkResult("t5a", 16'h4444, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 16'(16'h1357 * (i + 1));
            b = 16'(16'h0F0F ^ i);
            tick();
            checkOutput("t5_hold_valid",    32'(out_valid), 32'd1);
            checkOutput("t5_hold_in_ready", 32'(in_ready),  32'd0);
            checkOutput("t5_hold_diff",     32'(diff),      32'h4444);
        end
        a         = 16'h0300;
        b         = 16'h0100;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t5_idle_valid",    32'(out_valid), 32'd0);
        checkOutput("t5_idle_in_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("t5_accepted", 32'(in_ready), 32'd0);
        checkResult("t5b", 16'h0200, 1'b0, 1'b0);
        finishOp("t5b");

        $display("[TB] out_ready high before out_valid");
        out_ready = 1'b1;
        applyStimulus(16'h00FF, 16'h000F);
        checkResult("t5c", 16'h00F0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        checkOutput("t5c_valid_drop", 32'(out_valid), 32'd0);

        $display("[TB] reset during RUN");
        a        = 16'hFFFF;
        b        = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid",    32'(out_valid), 32'd0);
        checkOutput("t6_rst_diff",     32'(diff),      32'd0);
        checkOutput("t6_rst_in_ready", 32'(in_ready),  32'd1);
        tick();
        checkOutput("t6_held_in_ready", 32'(in_ready),  32'd1);
        checkOutput("t6_held_valid",    32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("t6_post_in_ready", 32'(in_ready),  32'd1);
        checkOutput("t6_post_valid",    32'(out_valid), 32'd0);
        checkOutput("t6_post_diff",     32'(diff),      32'd0);
        applyStimulus(16'h0010, 16'h0001);
        checkResult("t6", 16'h000F, 1'b0, 1'b0);
        finishOp("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
